// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared constants and the divisor clamp used by clock_divider_n and by the
// timer top that instantiates it.
//   CLKDIV_MIN          smallest legal divide ratio
//   CLKDIV_WIDTH        default divisor/counter width
//   CLKDIV_DEFAULT_DIV  default divisor loaded at reset
//   eff()               clamps a requested divisor to at least CLKDIV_MIN
// -----------------------------------------------------------------------------
package clkdiv_pkg;

  localparam int unsigned CLKDIV_MIN         = 2;
  localparam int          CLKDIV_WIDTH       = 8;
  localparam int          CLKDIV_DEFAULT_DIV = 10;

  // Ratios 0 and 1 cannot produce a two-phase output, so they become 2.
  function automatic int unsigned eff(input int unsigned d);
    return (d < CLKDIV_MIN) ? CLKDIV_MIN : d;
  endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// -----------------------------------------------------------------------------
// clkdiv_counter
// Period counter for clock_divider_n. Counts 0 .. div_active-1 while enabled
// and holds at 0 while idle.
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_enable      1 = run, 0 = idle (count and running cleared)
//   i_div_active  divide ratio governing the current period
//   o_count_next  value the count register takes on the next edge
//   o_wrap        period boundary: o_count_next is 0 on this edge (wrap from
//                 the last count, first edge after enable, or idle)
// -----------------------------------------------------------------------------
module clkdiv_counter
  import clkdiv_pkg::*;
#(
  parameter int WIDTH = CLKDIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_div_active,
  output logic [WIDTH-1:0] o_count_next,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_count;
  logic             r_running;
  logic             w_last;

  assign w_last = (r_count == (i_div_active - WIDTH'(1)));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    o_count_next = '0;
    if (i_enable && r_running && !w_last) begin
      o_count_next = r_count + WIDTH'(1);
    end
    o_wrap = (o_count_next == '0);
  end

  // running is simply Enable delayed by one edge: the first enabled edge
  // sees running=0 and restarts the count at 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      r_count   <= '0;
      r_running <= 1'b0;
    end else begin
      r_count   <= o_count_next;
      r_running <= i_enable;
    end
  end

endmodule

// File: rtl/clock_divider_n.sv
// -----------------------------------------------------------------------------
// clock_divider_n
// Programmable integer clock divider. Produces a registered divided clock
// (high ceil(N/2), low floor(N/2) cycles) and, optionally, a one-cycle tick in
// the last cycle of each period. A new divisor is captured on i_load and only
// committed at a period boundary, so no runt pulses are produced.
//   i_clockin   system clock, rising edge
//   i_resetn    asynchronous active-low reset
//   i_enable    1 = run, 0 = hold idle (outputs low)
//   i_divisor   requested divide ratio; 0 and 1 are treated as 2
//   i_load      one-cycle strobe capturing i_divisor
//   o_clockout  divided clock, straight from a flop
//   o_tick      terminal-count pulse, straight from a flop
//               (present only when CLKDIV_TICK_EN is defined)
// Build option: `define CLKDIV_TICK_EN to add the o_tick port and register.
// -----------------------------------------------------------------------------
module clock_divider_n
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = CLKDIV_WIDTH,
  parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic             i_clockin,
  input  logic             i_resetn,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_load,
  output logic             o_clockout
`ifdef CLKDIV_TICK_EN
  ,
  output logic             o_tick
`endif
);

  logic [WIDTH-1:0] r_div_active;
  logic [WIDTH-1:0] r_div_pending;
  logic             r_pend;
  logic             r_clockout;

  logic [WIDTH-1:0] w_count_next;
  logic             w_wrap;
  logic [WIDTH-1:0] w_div_eff;
  logic             w_commit;
  logic [WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0] w_half;
  logic             w_clockout_next;

  clkdiv_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .i_clk        (i_clockin),
    .i_rst_n      (i_resetn),
    .i_enable     (i_enable),
    .i_div_active (r_div_active),
    .o_count_next (w_count_next),
    .o_wrap       (w_wrap)
  );

  assign w_div_eff = WIDTH'(eff(32'(i_divisor)));

  // At a boundary a Load in the same cycle beats an older pending value.
  // The output flops must see the ratio of the period that starts now, so
  // they use w_div_next rather than r_div_active.
  assign w_commit   = w_wrap && (i_load || r_pend);
  assign w_div_next = w_commit ? (i_load ? w_div_eff : r_div_pending)
                               : r_div_active;

  // ceil(N/2) without needing an extra bit for N+1.
  assign w_half          = (w_div_next >> 1) + {{(WIDTH-1){1'b0}}, w_div_next[0]};
  assign w_clockout_next = i_enable && (w_count_next < w_half);

  always_ff @(posedge i_clockin or negedge i_resetn) begin
    if (!i_resetn) begin
      r_div_active  <= WIDTH'(DEFAULT_DIV);
      r_div_pending <= WIDTH'(DEFAULT_DIV);
      r_pend        <= 1'b0;
      r_clockout    <= 1'b0;
    end else begin
      if (i_load) begin
        r_div_pending <= w_div_eff;
        r_pend        <= 1'b1;
      end
      // Boundary update comes last so it overrides the pend set above.
      if (w_wrap) begin
        r_div_active <= w_div_next;
        r_pend       <= 1'b0;
      end
      r_clockout <= w_clockout_next;
    end
  end

  assign o_clockout = r_clockout;

`ifdef CLKDIV_TICK_EN
  logic r_tick;
  logic w_tick_next;

  assign w_tick_next = i_enable && (w_count_next == (w_div_next - WIDTH'(1)));

  always_ff @(posedge i_clockin or negedge i_resetn) begin
    if (!i_resetn) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick_next;
    end
  end

  assign o_tick = r_tick;
`endif

endmodule

// File: tb/tb_clock_divider_n.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_n
// Self-checking bench for clock_divider_n (default WIDTH=8, DEFAULT_DIV=10).
// Tick is checked only when CLKDIV_TICK_EN is defined.
// -----------------------------------------------------------------------------
module tb_clock_divider_n;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       ld;
  logic [7:0] div;
  logic       clockout;
`ifdef CLKDIV_TICK_EN
  logic       tick;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  clock_divider_n dut (
    .i_clockin  (clk),
    .i_resetn   (rst_n),
    .i_enable   (en),
    .i_divisor  (div),
    .i_load     (ld),
    .o_clockout (clockout)
`ifdef CLKDIV_TICK_EN
    ,
    .o_tick     (tick)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, required to finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: position within the current output period, the ratio of
  // that period, and the latest requested ratio waiting for a boundary.
  // ---------------------------------------------------------------------------
  int m_pos;      // -1 when idle
  int m_n;
  int m_req;
  bit m_req_v;
  bit m_clk;
  bit m_tick;

  function automatic int clamp(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    m_pos = -1; m_n = 10; m_req_v = 0; m_clk = 0; m_tick = 0;
  endtask

  task automatic model_step(input bit e, input bit l, input int d);
    if (!e) begin
      if (l)            m_n = clamp(d);
      else if (m_req_v) m_n = m_req;
      m_req_v = 0;
      m_pos   = -1;
      m_clk   = 0;
      m_tick  = 0;
    end else begin
      if (m_pos < 0 || m_pos == m_n - 1) begin
        if (l)            m_n = clamp(d);
        else if (m_req_v) m_n = m_req;
        m_req_v = 0;
        m_pos   = 0;
      end else begin
        m_pos = m_pos + 1;
        if (l) begin
          m_req   = clamp(d);
          m_req_v = 1;
        end
      end
      m_clk  = (m_pos < (m_n + 1) / 2);
      m_tick = (m_pos == m_n - 1);
    end
  endtask

  task automatic step(input bit e, input bit l, input int d, input string name);
    en  = e;
    ld  = l;
    div = 8'(d);
    @(posedge clk);
    model_step(e, l, d);
    #1;
    check({name, "_clk"}, {31'd0, clockout}, {31'd0, m_clk});
`ifdef CLKDIV_TICK_EN
    check({name, "_tick"}, {31'd0, tick}, {31'd0, m_tick});
`endif
    ld = 1'b0;
  endtask

  // Measures one high phase and the following low phase. With align=1 it
  // first runs until Clockout rises; otherwise the current sample must be the
  // first high cycle. Ends on the sample where Clockout rises again.
  task automatic measure(input string name, input int hi, input int lo, input bit align);
    int budget;
    int h;
    int l;
    bit prev;
    budget = 0;
    if (align) begin
      do begin
        prev = clockout;
        step(1, 0, 0, name);
        budget++;
      end while (!(clockout && !prev) && budget < 600);
      if (budget >= 600) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_align: no rising edge within 600 cycles, required one", name);
      end
    end
    h = 0;
    while (clockout === 1'b1 && h < 600) begin
      h++;
      step(1, 0, 0, name);
    end
    l = 0;
    while (clockout === 1'b0 && l < 600) begin
      l++;
      step(1, 0, 0, name);
    end
    check({name, "_high"}, h, hi);
    check({name, "_low"}, l, lo);
  endtask

  typedef struct {
    bit e;
    bit l;
    int d;
    bit c;
    bit t;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit e, input bit l, input int d, input bit c, input bit t);
    vec_t v;
    v.e = e; v.l = l; v.d = d; v.c = c; v.t = t;
    return v;
  endfunction

  initial begin
    // N=10 from reset, then Load 3 while count=4.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 3, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0));

    rst_n = 1'b0;
    en    = 1'b0;
    ld    = 1'b0;
    div   = 8'd0;
    model_reset();
    #12;
    check("reset_clk", {31'd0, clockout}, 32'd0);
`ifdef CLKDIV_TICK_EN
    check("reset_tick", {31'd0, tick}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      en  = vecs[i].e;
      ld  = vecs[i].l;
      div = 8'(vecs[i].d);
      @(posedge clk);
      model_step(vecs[i].e, vecs[i].l, vecs[i].d);
      #1;
      check($sformatf("vec%0d_clk", i), {31'd0, clockout}, {31'd0, vecs[i].c});
`ifdef CLKDIV_TICK_EN
      check($sformatf("vec%0d_tick", i), {31'd0, tick}, {31'd0, vecs[i].t});
`endif
      ld = 1'b0;
    end

    // Divisors 0 and 1 behave as 2.
    step(1, 1, 0, "ld0");
    measure("n0", 1, 1, 1);
    step(1, 1, 1, "ld1");
    measure("n1", 1, 1, 1);

    // Back to 10, then Load 7 and Load 4 within one period: 4 wins.
    step(1, 1, 10, "ld10");
    measure("n10", 5, 5, 1);
    step(1, 1, 7, "ld7");
    step(1, 1, 4, "ld4");
    measure("n4", 2, 2, 1);

    // Load in the wrap cycle: sample is count 0, run to count 3, then load.
    step(1, 0, 0, "pre_wrap");
    step(1, 0, 0, "pre_wrap");
    step(1, 0, 0, "pre_wrap");
    step(1, 1, 5, "wrap_ld5");
    measure("wrap5", 3, 2, 0);

    // Enable drop at count=2, then clean restart.
    step(1, 0, 0, "run");
    step(1, 0, 0, "run");
    step(0, 0, 0, "drop");
    check("drop_low", {31'd0, clockout}, 32'd0);
    step(0, 0, 0, "idle");
    step(1, 0, 0, "restart");
    check("restart_high", {31'd0, clockout}, 32'd1);
    measure("restart5", 3, 2, 0);

    // Asynchronous reset in the middle of a high phase.
    step(1, 1, 6, "ld6");
    measure("n6", 3, 3, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clk", {31'd0, clockout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1, 0, 0, "post_reset");
    measure("default10", 5, 5, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_divider_n.md
# clock_divider_n

Parametrised integer clock divider that generates a divided clock and a terminal-count tick from Clockin. The divisor is programmable at run time, and a new divisor only takes effect at a period boundary, so the output never produces a runt pulse. It replaces the fixed divide-by-2/5/10 chain. It feeds the seconds-timer counters and any other slow-rate enables in the design.

## Interface
- WIDTH, default 8: width of the divisor and the internal counter. Maximum divisor is 2^WIDTH-1.
- DEFAULT_DIV, default 10: divisor loaded at reset. Must be ≥2 and ≤2^WIDTH-1.
- Clockin  in  1  single system clock; all logic is on the rising edge.
- Resetn  in  1  asynchronous active-low reset.
- Enable  in  1  1 = run; 0 = hold the divider idle.
- Divisor  in  WIDTH  requested divide ratio N; values 0 and 1 are clamped to 2.
- Load  in  1  one-cycle strobe that captures Divisor.
- Clockout  out  1  divided clock, registered.
- Tick  out  1  one-cycle pulse in the last cycle of each output period (only when CLKDIV_TICK_EN is defined).

## Operation
- State:
  - count, WIDTH bits.
  - div_active, WIDTH bits.
  - div_pending, WIDTH bits.
  - pend, 1 bit.
  - running, 1 bit.
  - Clockout register.
  - Tick register.
- Reset values:
  - count = 0.
  - div_active = div_pending = DEFAULT_DIV.
  - pend = 0, running = 0.
  - Clockout = 0, Tick = 0.
- Idle (Enable=0): count = 0, running = 0, Clockout = 0, Tick = 0.
  - A pending divisor is committed to div_active on the next edge.
  - A Load in the same cycle commits Divisor directly.
- Start: the first edge with Enable=1 and running=0 sets count_next = 0 and running = 1.
- Run: count_next = 0 if count == div_active-1, otherwise count+1.
- Output rule, registered with count: Clockout <= (count_next < ceil(N/2)).
  - Result: high for ceil(N/2) cycles, low for floor(N/2) cycles.
  - N=10 gives 5/5; N=3 gives 2/1; N=2 gives 1/1.
- Tick <= (count_next == N-1).
- Clamp: eff(D) = 2 if D < 2, otherwise D. The clamp is applied when Divisor is captured.
- Load while running:
  - div_pending <= eff(Divisor), pend <= 1.
  - If several Loads arrive before a wrap, the last one wins.
- Commit at wrap (count_next == 0 while running):
  - div_active <= Load ? eff(Divisor) : div_pending, applied only if Load or pend is set.
  - pend is then cleared.
  - A Load in the wrap cycle itself takes effect at that wrap.
  - The new N governs the period that starts at count 0.
- Enable dropping mid-period: the output goes low on the next edge. There is no attempt to finish the period.
- Resetn asserted mid-operation: all registers return to their reset values immediately, independent of the clock.

## Timing
- Clockout and Tick come straight from flops; there is no combinational path from any input to any output.
- Enable rise to first Clockout high: 1 edge.
- Period is exactly N Clockin cycles for every period after start.
- Divisor change latency: the new value applies at the first wrap at or after Load. Worst case is N_old cycles.
- Resetn deassertion must meet recovery against Clockin. A synchroniser is outside this block.

## Configuration
- CLKDIV_TICK_EN defined:
  - The Tick port and register exist and behave as described above.
  - The timer uses Tick as a clock enable rather than clocking downstream logic from Clockout.
- CLKDIV_TICK_EN undefined:
  - No Tick port and no Tick register.
  - Clockout behaviour is identical.

## Structure
- Package clkdiv_pkg holds:
  - CLKDIV_MIN = 2.
  - The eff() clamp function.
  - Default WIDTH and DEFAULT_DIV constants shared with the timer top.
- Sub-module clkdiv_counter contains:
  - the count register and wrap detection;
  - outputs count_next and wrap.
- The top level owns divisor capture/commit and the output flops.

## Test plan
- Reset then Enable=1 with N=10:
  - Clockout is high for 5 cycles, then low for 5, repeating.
  - Tick pulses once every 10 cycles, in the cycle before Clockout rises.
- Load Divisor=3 mid-period (count=4, N=10):
  - The old period completes (10 cycles total).
  - Following periods are 2 high / 1 low.
- Load Divisor=0 and Divisor=1:
  - Both behave as N=2: alternating 1/1, Tick every 2 cycles.
- Load 7 then Load 4 before a wrap: the next periods are 4 cycles, not 7.
- Load coincident with the wrap edge: the new N takes effect on the period starting at that wrap.
- Enable drop at count=2:
  - Clockout is 0 on the next edge.
  - Re-enabling restarts cleanly: Clockout is high 1 edge later.
- Resetn pulsed mid-high phase:
  - Clockout goes to 0 without waiting for a Clockin edge.
  - div_active returns to DEFAULT_DIV.
